// File: rtl/addsub_result_stage.sv
// rtl/addsub_result_stage.sv - registered adder/subtractor result stage
// Optional overflow saturation, Z/N/V flags, 2-entry skid queue, sticky overflow and event counter.
module addsub_result_stage #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_s,
  input  logic          in_ovf,
  input  logic          in_sign_a,
  input  logic          sat_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_z,
  output logic          out_n,
  output logic          out_v,
  output logic          sticky_v,
  input  logic          clr_sticky,
  output logic [CW-1:0] ovf_count
);

  typedef struct packed {
    logic         v;
    logic         n;
    logic         z;
    logic [N-1:0] data;
  } entry_t;

  localparam logic [N-1:0] MOST_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  entry_t     head_q, tail_q;
  logic [1:0] count_q;

  entry_t       new_entry;
  logic [N-1:0] new_data;
  logic         push, pop;

  // in_ready depends only on registered count, never on out_ready
  assign in_ready  = !rst && (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    new_data = in_s;
    if (sat_en && in_ovf) begin
      new_data = in_sign_a ? MOST_NEG : MOST_POS;
    end
    new_entry.data = new_data;
    new_entry.z    = (new_data == '0);
    new_entry.n    = new_data[N-1];
    new_entry.v    = in_ovf;
  end

  // Shift structure: head_q is always the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_q  <= new_entry;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= new_entry;
          end else if (push) begin
            tail_q  <= new_entry;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_q  <= tail_q;
            count_q <= 2'd1;
          end
        end
      endcase
    end
  end

  assign out_data = head_q.data;
  assign out_z    = head_q.z;
  assign out_n    = head_q.n;
  assign out_v    = head_q.v;

  // An overflow push beats a coincident clear: the clear drops history, the new event still counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_v  <= 1'b0;
      ovf_count <= '0;
    end else if (push && in_ovf) begin
      sticky_v <= 1'b1;
      if (clr_sticky) begin
        ovf_count <= CW'(1);
      end else if (ovf_count != '1) begin
        ovf_count <= ovf_count + CW'(1);
      end
    end else if (clr_sticky) begin
      sticky_v  <= 1'b0;
      ovf_count <= '0;
    end
  end

endmodule

// File: tb/tb_addsub_result_stage.sv
// tb/tb_addsub_result_stage.sv - directed bench for addsub_result_stage
// Tasks per scenario with inline comparisons against hand-computed values.
module tb_addsub_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_s;
  logic       in_ovf, in_sign_a, sat_en;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_z, out_n, out_v;
  logic       sticky_v, clr_sticky;
  logic [7:0] ovf_count;

  int checks = 0;
  int failures = 0;

  addsub_result_stage #(.N(8), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_s(in_s), .in_ovf(in_ovf),
    .in_sign_a(in_sign_a), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_z(out_z), .out_n(out_n), .out_v(out_v),
    .sticky_v(sticky_v), .clr_sticky(clr_sticky), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] s, input logic ovf,
                       input logic sa, input logic sat);
    in_valid = v; in_s = s; in_ovf = ovf; in_sign_a = sa; sat_en = sat;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; clr_sticky = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(); step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if ({out_data, out_z, out_n, out_v} !== 11'h0) begin failures++; $display("FAIL reset_outputs got %h exp 0", {out_data, out_z, out_n, out_v}); end
    checks++; if ({sticky_v, ovf_count} !== 9'h0) begin failures++; $display("FAIL reset_sticky got %h exp 0", {sticky_v, ovf_count}); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    checks++; if ({out_data, out_z, out_n, out_v} !== {8'h05, 3'b000}) begin failures++; $display("FAIL basic_head got %h exp %h", {out_data, out_z, out_n, out_v}, {8'h05, 3'b000}); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    drive(1'b1, 8'h80, 1'b1, 1'b0, 1'b1);
    step();
    checks++; if ({out_valid, out_data, out_n, out_v} !== {1'b1, 8'h7F, 1'b0, 1'b1}) begin failures++; $display("FAIL sat_pos got %h exp %h", {out_valid, out_data, out_n, out_v}, {1'b1, 8'h7F, 1'b0, 1'b1}); end
    checks++; if ({sticky_v, ovf_count} !== {1'b1, 8'd1}) begin failures++; $display("FAIL sat_pos_sticky got %h exp %h", {sticky_v, ovf_count}, {1'b1, 8'd1}); end
    drive(1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
    step();
    checks++; if ({out_valid, out_data, out_n, out_v} !== {1'b1, 8'h80, 1'b1, 1'b1}) begin failures++; $display("FAIL sat_neg got %h exp %h", {out_valid, out_data, out_n, out_v}, {1'b1, 8'h80, 1'b1, 1'b1}); end
    drive(1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if ({out_valid, out_data, out_n, out_v} !== {1'b1, 8'h80, 1'b1, 1'b1}) begin failures++; $display("FAIL nosat got %h exp %h", {out_valid, out_data, out_n, out_v}, {1'b1, 8'h80, 1'b1, 1'b1}); end
    checks++; if (ovf_count !== 8'd3) begin failures++; $display("FAIL sat_count got %0d exp 3", ovf_count); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got %b exp 0", in_ready); end
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if ({in_ready, out_valid, out_data} !== {2'b01, 8'h11}) begin failures++; $display("FAIL bp_hold got %h exp %h", {in_ready, out_valid, out_data}, {2'b01, 8'h11}); end
    out_ready = 1'b1;
    step();
    checks++; if ({in_ready, out_valid, out_data} !== {2'b11, 8'h22}) begin failures++; $display("FAIL bp_second got %h exp %h", {in_ready, out_valid, out_data}, {2'b11, 8'h22}); end
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if ({out_valid, out_data} !== {1'b1, 8'h33}) begin failures++; $display("FAIL bp_third got %h exp %h", {out_valid, out_data}, {1'b1, 8'h33}); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step();
    out_ready = 1'b1;
    drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if ({in_ready, out_valid, out_data} !== {2'b11, 8'h44}) begin failures++; $display("FAIL pp_head got %h exp %h", {in_ready, out_valid, out_data}, {2'b11, 8'h44}); end
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if ({out_valid, out_data, out_z, out_n} !== {1'b1, 8'h00, 2'b10}) begin failures++; $display("FAIL pp_zero got %h exp %h", {out_valid, out_data, out_z, out_n}, {1'b1, 8'h00, 2'b10}); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_sticky_counter();
    out_ready = 1'b1;
    clr_sticky = 1'b1;
    drive(1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if ({sticky_v, ovf_count} !== {1'b1, 8'd1}) begin failures++; $display("FAIL clr_vs_set got %h exp %h", {sticky_v, ovf_count}, {1'b1, 8'd1}); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if ({sticky_v, ovf_count} !== 9'h0) begin failures++; $display("FAIL clr_alone got %h exp 0", {sticky_v, ovf_count}); end
    clr_sticky = 1'b0;
    drive(1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 260; i++) begin
      step();
      if (i == 254) begin
        checks++; if (ovf_count !== 8'hFE) begin failures++; $display("FAIL cnt_254 got %h exp fe", ovf_count); end
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (ovf_count !== 8'hFF) begin failures++; $display("FAIL cnt_sat got %h exp ff", ovf_count); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if ({in_ready, out_valid, out_data} !== {2'b01, 8'hA5}) begin failures++; $display("FAIL rm_full got %h exp %h", {in_ready, out_valid, out_data}, {2'b01, 8'hA5}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({in_ready, out_valid} !== 2'b00) begin failures++; $display("FAIL rm_async got %b exp 00", {in_ready, out_valid}); end
    checks++; if ({out_data, out_z, out_n, out_v, sticky_v, ovf_count} !== 20'h0) begin failures++; $display("FAIL rm_outputs got %h exp 0", {out_data, out_z, out_n, out_v, sticky_v, ovf_count}); end
    out_ready = 1'b1;
    step();
    #2 rst = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL rm_release got %b exp 10", {in_ready, out_valid}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_push_pop();
    test_sticky_counter();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
